mant_align: RTL
===============

MANT_ALIGN -- requirements
Module: mant_align

Interface
REQ-001 SHALL have parameter m, default 8, exponent width.
REQ-002 SHALL have parameter n, default 23, fraction width; mantissa fields are n+2 bits (hidden + guard).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 exp_a, exp_b  input  m  biased exponents of operands A and B.
REQ-008 mant_a, mant_b  input  n+2  mantissas of operands A and B.
REQ-009 out_valid  output  1  aligned result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 exp_out  output  m  larger exponent, the common exponent after alignment.
REQ-012 mant_big  output  n+2  mantissa of the larger-exponent operand, unshifted.
REQ-013 mant_small  output  n+2  mantissa of the smaller-exponent operand, right-shifted by the exponent difference.
REQ-014 sticky  output  1  OR of all bits shifted out of mant_small.
REQ-015 swapped  output  1  1 when B supplied mant_big.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 Accept cycle T, where in_valid&&in_ready: SHALL compute diff=|exp_a-exp_b| at m-bit width without overflow.
REQ-018 On accept, the big operand SHALL be A when exp_a>=exp_b, so equal exponents give swapped=0; otherwise B, giving swapped=1.
REQ-019 On accept, SHALL register exp_out, mant_big, swapped, the unshifted small mantissa, counter cnt=diff, and sticky=0.
REQ-020 diff==0: next state DONE; mant_small = small mantissa; sticky=0; out_valid at T+1.
REQ-021 diff>n+2 (25 by default): next state DONE; mant_small=0; sticky=OR of the whole small mantissa; out_valid at T+1.
REQ-022 1<=diff<=n+2: next state SHIFT; each SHIFT cycle does sticky|=mant_small[0], then mant_small>>=1 with zero fill, then cnt-=1.
REQ-023 Leave SHIFT for DONE on the cycle cnt goes 1->0; out_valid at T+1+diff.
REQ-024 DONE SHALL hold all outputs stable until out_ready=1, then return to IDLE.
REQ-025 A new operand pair SHALL NOT be accepted in the same cycle the result is consumed, giving minimum throughput 1 op / 2 cycles.
REQ-026 in_valid while not IDLE SHALL be ignored; input values outside the accept cycle SHALL have no effect.
REQ-027 out_ready while not DONE SHALL be ignored.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, cnt=0, and all outputs 0, except in_ready=1 once state is IDLE.
REQ-029 Reset during SHIFT or DONE SHALL discard the in-flight operation with no output beat.
REQ-030 First accept SHALL be possible on the first clock edge after rst deasserts.

Structure
REQ-031 A shared package float_pkg SHALL hold M, N, the derived mantissa width N+2, and the state enum.
REQ-032 The exponent compare/swap logic SHALL be sub-module exp_diff; the FSM and shift datapath stay in mant_align.
REQ-033 The shift SHALL be 1 bit/cycle; a single right shifter and no barrel shifter.

Verification
REQ-034 exp_a=0x85, mant_a=0x0C00000, exp_b=0x82, mant_b=0x0A00001 -> out_valid at T+4: exp_out=0x85, mant_big=0x0C00000, mant_small=0x0140000, sticky=1, swapped=0.
REQ-035 exp_a=exp_b=0x7F, mant_a=0x1000000, mant_b=0x0800000 -> out_valid at T+1: mant_small=0x0800000, sticky=0, swapped=0.
REQ-036 exp_a=0x10, exp_b=0x90, mant_a=0x0000001 -> out_valid at T+1: exp_out=0x90, mant_small=0, sticky=1, swapped=1; with mant_a=0 instead, sticky=0.
REQ-037 diff=25 with mant_small input 0x1000000 -> out_valid at T+26: mant_small=0, sticky=1.
REQ-038 out_ready held 0 for 5 cycles in DONE -> outputs stable; in_valid pulses ignored; accept occurs only after return to IDLE.
REQ-039 rst asserted mid-SHIFT -> next edge in IDLE, outputs 0, no out_valid; a fresh op afterwards completes correctly.

Source files
------------

// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared floating-point field widths and alignment FSM states
package float_pkg;

    localparam int M  = 8;
    localparam int N  = 23;
    localparam int MW = N + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/exp_diff.sv
// rtl/exp_diff.sv - exponent compare and operand swap for mantissa alignment
module exp_diff
    import float_pkg::*;
#(
    parameter int m = M,
    parameter int n = N
) (
    input  logic [m-1:0]   exp_a,
    input  logic [m-1:0]   exp_b,
    input  logic [n+1:0]   mant_a,
    input  logic [n+1:0]   mant_b,
    output logic [m-1:0]   exp_big,
    output logic [m-1:0]   diff,
    output logic [n+1:0]   mant_big,
    output logic [n+1:0]   mant_small,
    output logic           swapped
);

    // Ties keep A as the big operand; subtracting smaller from larger never wraps.
    assign swapped    = (exp_b > exp_a);
    assign exp_big    = swapped ? exp_b : exp_a;
    assign diff       = swapped ? (exp_b - exp_a) : (exp_a - exp_b);
    assign mant_big   = swapped ? mant_b : mant_a;
    assign mant_small = swapped ? mant_a : mant_b;

endmodule

// File: rtl/mant_align.sv
// rtl/mant_align.sv - aligns the smaller-exponent mantissa with a 1-bit/cycle shifter
module mant_align
    import float_pkg::*;
#(
    parameter int m = M,
    parameter int n = N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [m-1:0]   exp_a,
    input  logic [m-1:0]   exp_b,
    input  logic [n+1:0]   mant_a,
    input  logic [n+1:0]   mant_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [m-1:0]   exp_out,
    output logic [n+1:0]   mant_big,
    output logic [n+1:0]   mant_small,
    output logic           sticky,
    output logic           swapped
);

    localparam int unsigned W = n + 2;

    state_t         state_q, state_d;
    logic [m-1:0]   cnt_q, cnt_d;
    logic [m-1:0]   exp_q, exp_d;
    logic [n+1:0]   big_q, big_d;
    logic [n+1:0]   small_q, small_d;
    logic           sticky_q, sticky_d;
    logic           swapped_q, swapped_d;

    logic [m-1:0]   ed_exp;
    logic [m-1:0]   ed_diff;
    logic [n+1:0]   ed_big;
    logic [n+1:0]   ed_small;
    logic           ed_swapped;

    exp_diff #(
        .m (m),
        .n (n)
    ) u_exp_diff (
        .exp_a      (exp_a),
        .exp_b      (exp_b),
        .mant_a     (mant_a),
        .mant_b     (mant_b),
        .exp_big    (ed_exp),
        .diff       (ed_diff),
        .mant_big   (ed_big),
        .mant_small (ed_small),
        .swapped    (ed_swapped)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        big_d     = big_q;
        small_d   = small_q;
        sticky_d  = sticky_q;
        swapped_d = swapped_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_d     = ed_exp;
                    big_d     = ed_big;
                    small_d   = ed_small;
                    swapped_d = ed_swapped;
                    cnt_d     = ed_diff;
                    sticky_d  = 1'b0;
                    if (ed_diff == '0) begin
                        state_d = DONE;
                    end else if (32'(ed_diff) > W) begin
                        // Everything falls off the end: resolve in one cycle.
                        small_d  = '0;
                        sticky_d = |ed_small;
                        state_d  = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sticky_d = sticky_q | small_q[0];
                small_d  = {1'b0, small_q[n+1:1]};
                cnt_d    = cnt_q - m'(1);
                if (cnt_q == m'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            exp_q     <= '0;
            big_q     <= '0;
            small_q   <= '0;
            sticky_q  <= 1'b0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            big_q     <= big_d;
            small_q   <= small_d;
            sticky_q  <= sticky_d;
            swapped_q <= swapped_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign exp_out    = exp_q;
    assign mant_big   = big_q;
    assign mant_small = small_q;
    assign sticky     = sticky_q;
    assign swapped    = swapped_q;

endmodule
